// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if : digit data/control in, multiplexed 7-segment drive out
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seg7_scan_driver_if;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        mode;
  logic        blank_lz;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  modport master (
    output digits, dp, mode, blank_lz, digit_en,
    input  an, seg, dp_n, frame_done
  );

  modport slave (
    input  digits, dp, mode, blank_lz, digit_en,
    output an, seg, dp_n, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver : 4-digit time-multiplexed 7-segment driver, tear-free frames
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  seg7_scan_driver_if.slave bus
);

  localparam int                 CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]   C_CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]   C_BLANK   = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             r_primed;
  logic [15:0]      r_sh_digits;
  logic [3:0]       r_sh_dp;
  logic             r_sh_mode;
  logic             r_sh_blank_lz;
  logic [3:0]       r_sh_en;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp_n;
  logic             r_frame_done;

  logic             w_tick;
  logic             w_latch;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_idx_nxt;
  logic [15:0]      w_digits_nxt;
  logic [3:0]       w_dp_nxt;
  logic             w_mode_nxt;
  logic             w_blank_lz_nxt;
  logic [3:0]       w_en_nxt;
  logic [3:0]       w_code;
  logic [15:0]      w_upper;
  logic             w_lz_dark;
  logic             w_lit;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_n_nxt;

  function automatic logic [6:0] hex_glyph(input logic [3:0] code);
    case (code)
      4'h0:    hex_glyph = 7'h40;
      4'h1:    hex_glyph = 7'h79;
      4'h2:    hex_glyph = 7'h24;
      4'h3:    hex_glyph = 7'h30;
      4'h4:    hex_glyph = 7'h19;
      4'h5:    hex_glyph = 7'h12;
      4'h6:    hex_glyph = 7'h02;
      4'h7:    hex_glyph = 7'h78;
      4'h8:    hex_glyph = 7'h00;
      4'h9:    hex_glyph = 7'h10;
      4'hA:    hex_glyph = 7'h08;
      4'hB:    hex_glyph = 7'h03;
      4'hC:    hex_glyph = 7'h46;
      4'hD:    hex_glyph = 7'h21;
      4'hE:    hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  // Until primed, the first tick only latches a frame and parks the index at 0.
  assign w_tick    = (r_cnt == C_CNT_MAX);
  assign w_latch   = w_tick && (!r_primed || (r_idx == 2'd3));
  assign w_cnt_nxt = w_tick ? '0 : r_cnt + CNT_W'(1);
  assign w_idx_nxt = w_tick ? (r_primed ? r_idx + 2'd1 : 2'd0) : r_idx;

  assign w_digits_nxt   = w_latch ? bus.digits   : r_sh_digits;
  assign w_dp_nxt       = w_latch ? bus.dp       : r_sh_dp;
  assign w_mode_nxt     = w_latch ? bus.mode     : r_sh_mode;
  assign w_blank_lz_nxt = w_latch ? bus.blank_lz : r_sh_blank_lz;
  assign w_en_nxt       = w_latch ? bus.digit_en : r_sh_en;

  // Output registers are fed from next-state values so the drive lines up
  // exactly with the slot and blank window the counters are entering.
  always_comb begin
    w_an_nxt   = 4'hF;
    w_seg_nxt  = 7'h7F;
    w_dp_n_nxt = 1'b1;
    w_code     = w_digits_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_upper    = w_digits_nxt >> {w_idx_nxt, 2'b00};
    w_lz_dark  = w_blank_lz_nxt && (w_idx_nxt != 2'd0) && (w_upper == 16'h0000);
    w_lit      = (w_cnt_nxt >= C_BLANK) && w_en_nxt[w_idx_nxt] && !w_lz_dark;
    if (w_lit) begin
      w_an_nxt   = ~(4'b0001 << w_idx_nxt);
      w_seg_nxt  = (w_mode_nxt && (w_code > 4'd9)) ? 7'h3F : hex_glyph(w_code);
      w_dp_n_nxt = ~w_dp_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_idx         <= 2'd0;
      r_primed      <= 1'b0;
      r_sh_digits   <= 16'h0000;
      r_sh_dp       <= 4'h0;
      r_sh_mode     <= 1'b0;
      r_sh_blank_lz <= 1'b0;
      r_sh_en       <= 4'h0;
      r_an          <= 4'hF;
      r_seg         <= 7'h7F;
      r_dp_n        <= 1'b1;
      r_frame_done  <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_primed      <= r_primed | w_tick;
      r_sh_digits   <= w_digits_nxt;
      r_sh_dp       <= w_dp_nxt;
      r_sh_mode     <= w_mode_nxt;
      r_sh_blank_lz <= w_blank_lz_nxt;
      r_sh_en       <= w_en_nxt;
      r_an          <= w_an_nxt;
      r_seg         <= w_seg_nxt;
      r_dp_n        <= w_dp_n_nxt;
      r_frame_done  <= w_latch;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp_n       = r_dp_n;
  assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver : random stimulus against a time-indexed reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_driver;

  localparam int DIV = 4;
  localparam int BLK = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release plus the snapshot taken per frame
  int          t;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic [3:0]  m_en;
  logic        m_mode;
  logic        m_blz;
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, act, exp);
    end
  endtask

  task automatic expect_outputs();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;
    logic [3:0]  one;
    logic [15:0] upper;
    int          u, slot, pos, code;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_fd  = 1'b0;
    one   = 4'b0001;
    if (t >= DIV) begin
      u     = t - DIV;
      slot  = (u / DIV) % 4;
      pos   = u % DIV;
      e_fd  = ((u % (4 * DIV)) == 0);
      upper = m_digits >> (4 * slot);
      code  = int'(upper) % 16;
      if (pos >= BLK && m_en[slot] && !(m_blz && slot > 0 && upper == 16'h0)) begin
        e_an  = ~(one << slot);
        e_seg = (m_mode && code > 9) ? 7'h3F : glyph[code];
        e_dp  = ~m_dp[slot];
      end
    end
    check_value("an",         32'(bus.an),         32'(e_an));
    check_value("seg",        32'(bus.seg),        32'(e_seg));
    check_value("dp_n",       32'(bus.dp_n),       32'(e_dp));
    check_value("frame_done", 32'(bus.frame_done), 32'(e_fd));
  endtask

  task automatic step();
    @(posedge clk);
    t++;
    if (t >= DIV && ((t - DIV) % (4 * DIV)) == 0) begin
      m_digits = bus.digits;
      m_dp     = bus.dp;
      m_en     = bus.digit_en;
      m_mode   = bus.mode;
      m_blz    = bus.blank_lz;
    end
    #1;
    expect_outputs();
  endtask

  task automatic apply(input logic [15:0] d, input logic [3:0] p, input logic md,
                       input logic lz, input logic [3:0] en, input int n);
    bus.digits   = d;
    bus.dp       = p;
    bus.mode     = md;
    bus.blank_lz = lz;
    bus.digit_en = en;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_inputs();
    case ($urandom_range(0, 3))
      0:       bus.digits = 16'($urandom);
      1:       bus.digits = 16'($urandom) & 16'h00FF;
      2:       bus.digits = 16'($urandom) & 16'h000F;
      default: bus.digits = 16'h0000;
    endcase
    bus.dp       = 4'($urandom);
    bus.mode     = 1'($urandom);
    bus.blank_lz = 1'($urandom);
    bus.digit_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
  endtask

  // Entered at posedge+1; asserts reset asynchronously mid-cycle.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check_value("rst_an",   32'(bus.an),         32'h0000000F);
    check_value("rst_seg",  32'(bus.seg),        32'h0000007F);
    check_value("rst_dp_n", 32'(bus.dp_n),       32'h00000001);
    check_value("rst_fd",   32'(bus.frame_done), 32'h00000000);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    t = 0;
  endtask

  initial begin
    reset        = 1'b1;
    t            = 0;
    m_digits     = 16'h0;
    m_dp         = 4'h0;
    m_en         = 4'h0;
    m_mode       = 1'b0;
    m_blz        = 1'b0;
    bus.digits   = 16'h1234;
    bus.dp       = 4'h0;
    bus.mode     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.digit_en = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check_value("init_an",  32'(bus.an),         32'h0000000F);
    check_value("init_seg", 32'(bus.seg),        32'h0000007F);
    check_value("init_dp",  32'(bus.dp_n),       32'h00000001);
    check_value("init_fd",  32'(bus.frame_done), 32'h00000000);
    #1 reset = 1'b0;

    apply(16'h1234, 4'h0, 1'b0, 1'b0, 4'hF, DIV + 4 * DIV + DIV + 1);
    apply(16'h5678, 4'h0, 1'b0, 1'b0, 4'hF, 3 * 4 * DIV);
    apply(16'h00A0, 4'h0, 1'b1, 1'b1, 4'hF, 2 * 4 * DIV);
    apply(16'h0000, 4'b0100, 1'b0, 1'b1, 4'hF, 2 * 4 * DIV);
    apply(16'h9ABC, 4'hA, 1'b0, 1'b0, 4'b0101, 2 * 4 * DIV);
    apply(16'h9ABC, 4'h5, 1'b1, 1'b0, 4'hF, 2 * 4 * DIV + 2 * DIV + 1);

    do_reset();
    rand_inputs();
    for (int i = 0; i < 3 * 4 * DIV; i++) step();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) rand_inputs();
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
